gbx_burst_split: RTL

Splits multi-beat GBX bus requests into single-beat GBX requests for the single-beat GBX SRAM, which ignores `greqlen`. Sits directly upstream of the SRAM: slave port (`s_*`) faces the master/interconnect, master port (`m_*`) drives the SRAM. Handles one burst at a time. Re-attaches burst id/user to read responses and regenerates `grsplast`.

---
 rtl/gbx_pkg.sv | 41 ++++
 rtl/gbx_req_reg.sv | 104 ++++++++++
 rtl/gbx_burst_split.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gbx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gbx_pkg
// Description : Shared GBX bus definitions. Contains bus widths, the beat-size
//               encoding, the burst-splitter state encoding and the helper
//               that converts a beat size into a byte-address increment.
// Revision    : 1.0 - initial release
// ============================================================================
package gbx_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_LEN_W  = 4;
    localparam int c_SIZE_W = 2;

    // Beat size on greqsize; encoding 3 is not listed and behaves as WORD.
    typedef enum logic [1:0] {
        GBX_BYTE = 2'd0,
        GBX_HALF = 2'd1,
        GBX_WORD = 2'd2
    } gbx_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } gbx_split_state_t;

    // Byte distance between consecutive beats of a burst.
    function automatic logic [c_ADDR_W-1:0] gbx_beat_incr(input logic [c_SIZE_W-1:0] size);
        logic [c_ADDR_W-1:0] incr;
        case (size)
            GBX_BYTE: incr = 32'd1;
            GBX_HALF: incr = 32'd2;
            default:  incr = 32'd4;
        endcase
        return incr;
    endfunction

endpackage : gbx_pkg
`default_nettype wire

// File: rtl/gbx_req_reg.sv
`default_nettype none
// ============================================================================
// Module      : gbx_req_reg
// Description : One-entry valid/ready register for single-beat GBX requests.
//               Holds address, size, write flag, data, id and user. The entry
//               can be refilled in the same cycle it is drained, so a steady
//               stream passes at one beat per cycle.
// Ports       : clk, resetn         - clock, asynchronous active-low reset
//               i_valid / o_ready    - load side handshake
//               i_addr..i_user       - request fields to load
//               o_valid / i_ready    - drain side handshake
//               o_addr..o_user       - registered request fields
// Revision    : 1.0 - initial release
// ============================================================================
module gbx_req_reg
    import gbx_pkg::*;
#(
    parameter int ID_W   = 16,
    parameter int USER_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [c_ADDR_W-1:0] i_addr,
    input  logic [c_SIZE_W-1:0] i_size,
    input  logic                i_write,
    input  logic [c_DATA_W-1:0] i_data,
    input  logic [ID_W-1:0]     i_id,
    input  logic [USER_W-1:0]   i_user,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [c_ADDR_W-1:0] o_addr,
    output logic [c_SIZE_W-1:0] o_size,
    output logic                o_write,
    output logic [c_DATA_W-1:0] o_data,
    output logic [ID_W-1:0]     o_id,
    output logic [USER_W-1:0]   o_user
);

    logic                r_valid, w_valid_nxt;
    logic [c_ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [c_SIZE_W-1:0] r_size,  w_size_nxt;
    logic                r_write, w_write_nxt;
    logic [c_DATA_W-1:0] r_data,  w_data_nxt;
    logic [ID_W-1:0]     r_id,    w_id_nxt;
    logic [USER_W-1:0]   r_user,  w_user_nxt;
    logic                w_load;

    // Free when empty or when the current entry leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;

    always_comb begin
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_size_nxt  = r_size;
        w_write_nxt = r_write;
        w_data_nxt  = r_data;
        w_id_nxt    = r_id;
        w_user_nxt  = r_user;
        if (w_load) begin
            w_valid_nxt = 1'b1;
            w_addr_nxt  = i_addr;
            w_size_nxt  = i_size;
            w_write_nxt = i_write;
            w_data_nxt  = i_data;
            w_id_nxt    = i_id;
            w_user_nxt  = i_user;
        end else if (i_ready) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_user  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_size  <= w_size_nxt;
            r_write <= w_write_nxt;
            r_data  <= w_data_nxt;
            r_id    <= w_id_nxt;
            r_user  <= w_user_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_size  = r_size;
    assign o_write = r_write;
    assign o_data  = r_data;
    assign o_id    = r_id;
    assign o_user  = r_user;

endmodule : gbx_req_reg
`default_nettype wire

// File: rtl/gbx_burst_split.sv
`default_nettype none
// ============================================================================
// Module      : gbx_burst_split
// Description : Splits multi-beat GBX requests into single-beat requests for
//               a single-beat GBX SRAM. One burst in flight at a time. Read
//               responses pass through combinationally with the burst id/user
//               re-attached and grsplast regenerated from a beat counter.
// Ports       : clk, resetn    - clock, asynchronous active-low reset
//               s_greq* / s_grsp* - upstream (slave) request/response port
//               m_greq* / m_grsp* - downstream (master) port to the SRAM
// Revision    : 1.0 - initial release
// ============================================================================
module gbx_burst_split
    import gbx_pkg::*;
#(
    parameter int ID_W   = 16,
    parameter int USER_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    // upstream request
    input  logic                s_greqvalid,
    input  logic                s_greqwrite,
    input  logic                s_greqdvalid,
    input  logic                s_greqdlast,
    input  logic [c_ADDR_W-1:0] s_greqaddr,
    input  logic [c_LEN_W-1:0]  s_greqlen,
    input  logic [c_SIZE_W-1:0] s_greqsize,
    input  logic [ID_W-1:0]     s_greqid,
    input  logic [USER_W-1:0]   s_grequser,
    input  logic [c_DATA_W-1:0] s_greqdata,
    output logic                s_greqready,
    // upstream response
    output logic                s_grspvalid,
    output logic                s_grspwerr,
    output logic                s_grsprerr,
    output logic                s_grsplast,
    output logic [c_DATA_W-1:0] s_grspdata,
    output logic [ID_W-1:0]     s_grspid,
    output logic [USER_W-1:0]   s_grspuser,
    input  logic                s_grspready,
    // downstream request
    output logic                m_greqvalid,
    output logic                m_greqwrite,
    output logic                m_greqdvalid,
    output logic                m_greqdlast,
    output logic [c_ADDR_W-1:0] m_greqaddr,
    output logic [c_LEN_W-1:0]  m_greqlen,
    output logic [c_SIZE_W-1:0] m_greqsize,
    output logic [ID_W-1:0]     m_greqid,
    output logic [USER_W-1:0]   m_grequser,
    output logic [c_DATA_W-1:0] m_greqdata,
    input  logic                m_greqready,
    // downstream response
    input  logic                m_grspvalid,
    input  logic                m_grspwerr,
    input  logic                m_grsprerr,
    input  logic                m_grsplast,
    input  logic [c_DATA_W-1:0] m_grspdata,
    input  logic [ID_W-1:0]     m_grspid,
    input  logic [USER_W-1:0]   m_grspuser,
    output logic                m_grspready
);

    gbx_split_state_t    r_state, w_state_nxt;
    logic [c_ADDR_W-1:0] r_addr,  w_addr_nxt;   // address of the next beat to load
    logic [c_LEN_W-1:0]  r_len,   w_len_nxt;
    logic [c_SIZE_W-1:0] r_size,  w_size_nxt;
    logic [ID_W-1:0]     r_id,    w_id_nxt;
    logic [USER_W-1:0]   r_user,  w_user_nxt;
    logic                r_write, w_write_nxt;
    // One bit wider than len so a 16-beat read can count past beat 15.
    logic [c_LEN_W:0]    r_iss,   w_iss_nxt;
    logic [c_LEN_W-1:0]  r_rcv,   w_rcv_nxt;

    logic                w_rr;
    logic                w_ld_valid;
    logic [c_ADDR_W-1:0] w_ld_addr;
    logic [c_SIZE_W-1:0] w_ld_size;
    logic                w_ld_write;
    logic [c_DATA_W-1:0] w_ld_data;
    logic [ID_W-1:0]     w_ld_id;
    logic [USER_W-1:0]   w_ld_user;
    logic                w_in_rd;
    logic                w_rsp_hs;
    logic                w_unused;

    assign w_in_rd     = (r_state == S_RD);
    assign w_rsp_hs    = w_in_rd && m_grspvalid && s_grspready;
    assign s_greqready = !w_in_rd && w_rr;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_size_nxt  = r_size;
        w_id_nxt    = r_id;
        w_user_nxt  = r_user;
        w_write_nxt = r_write;
        w_iss_nxt   = r_iss;
        w_rcv_nxt   = r_rcv;
        w_ld_valid  = 1'b0;
        w_ld_addr   = r_addr;
        w_ld_size   = r_size;
        w_ld_write  = r_write;
        w_ld_id     = r_id;
        w_ld_user   = r_user;
        w_ld_data   = r_write ? s_greqdata : '0;

        case (r_state)
            S_IDLE: begin
                // Header acceptance also loads beat 0, so the first
                // downstream request appears the following cycle.
                if (s_greqvalid && w_rr) begin
                    w_addr_nxt  = s_greqaddr + gbx_beat_incr(s_greqsize);
                    w_len_nxt   = s_greqlen;
                    w_size_nxt  = s_greqsize;
                    w_id_nxt    = s_greqid;
                    w_user_nxt  = s_grequser;
                    w_write_nxt = s_greqwrite;
                    w_iss_nxt   = 5'd1;
                    w_rcv_nxt   = '0;
                    w_ld_valid  = 1'b1;
                    w_ld_addr   = s_greqaddr;
                    w_ld_size   = s_greqsize;
                    w_ld_write  = s_greqwrite;
                    w_ld_id     = s_greqid;
                    w_ld_user   = s_grequser;
                    w_ld_data   = s_greqwrite ? s_greqdata : '0;
                    if (!s_greqwrite) begin
                        w_state_nxt = S_RD;
                    end else if (s_greqlen != '0) begin
                        w_state_nxt = S_WR;
                    end
                end
            end

            S_WR: begin
                // Beat count decides the end of the burst; greqdlast is not used.
                if (s_greqdvalid && w_rr) begin
                    w_ld_valid = 1'b1;
                    w_addr_nxt = r_addr + gbx_beat_incr(r_size);
                    w_iss_nxt  = r_iss + 5'd1;
                    if (r_iss[c_LEN_W-1:0] == r_len) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_RD: begin
                if ((r_iss <= {1'b0, r_len}) && w_rr) begin
                    w_ld_valid = 1'b1;
                    w_addr_nxt = r_addr + gbx_beat_incr(r_size);
                    w_iss_nxt  = r_iss + 5'd1;
                end
                if (w_rsp_hs) begin
                    w_rcv_nxt = r_rcv + 4'd1;
                    if (r_rcv == r_len) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_id    <= '0;
            r_user  <= '0;
            r_write <= 1'b0;
            r_iss   <= '0;
            r_rcv   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_len   <= w_len_nxt;
            r_size  <= w_size_nxt;
            r_id    <= w_id_nxt;
            r_user  <= w_user_nxt;
            r_write <= w_write_nxt;
            r_iss   <= w_iss_nxt;
            r_rcv   <= w_rcv_nxt;
        end
    end

    gbx_req_reg #(
        .ID_W   (ID_W),
        .USER_W (USER_W)
    ) u_req_reg (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (w_ld_valid),
        .o_ready (w_rr),
        .i_addr  (w_ld_addr),
        .i_size  (w_ld_size),
        .i_write (w_ld_write),
        .i_data  (w_ld_data),
        .i_id    (w_ld_id),
        .i_user  (w_ld_user),
        .o_valid (m_greqvalid),
        .i_ready (m_greqready),
        .o_addr  (m_greqaddr),
        .o_size  (m_greqsize),
        .o_write (m_greqwrite),
        .o_data  (m_greqdata),
        .o_id    (m_greqid),
        .o_user  (m_grequser)
    );

    assign m_greqdvalid = m_greqwrite;
    assign m_greqdlast  = 1'b1;
    assign m_greqlen    = '0;

    // Responses only belong to a read burst; anything else is drained
    // downstream and hidden from the upstream port.
    assign s_grspvalid = w_in_rd && m_grspvalid;
    assign s_grspwerr  = w_in_rd && m_grspwerr;
    assign s_grsprerr  = w_in_rd && m_grsprerr;
    assign s_grsplast  = w_in_rd && (r_rcv == r_len);
    assign s_grspdata  = m_grspdata;
    assign s_grspid    = r_id;
    assign s_grspuser  = r_user;
    assign m_grspready = w_in_rd ? s_grspready : 1'b1;

    assign w_unused = &{1'b0, s_greqdlast, m_grsplast, m_grspid, m_grspuser};

endmodule : gbx_burst_split
`default_nettype wire
